// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//
// Receive-side frame controller for a UART. It sits after the RX edge/bit
// counter. It walks each serial frame through start, data, optional parity and
// stop. It samples RX_IN at mid-bit and deserializes the data LSB-first. When a
// frame completes, it publishes either the received byte or the error strobes.
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to take three samples
// (EDG_CNT = H-1, H, H+1) and use their 2-of-3 majority. Without it, only the
// sample at EDG_CNT = H is used, and the outer sample registers do not exist.
//
// Ports
//   CLK             oversampling clock
//   RST             synchronous reset, active low
//   RX_IN           serial line, idle high, already synchronized
//   PRESCALE        oversampling ratio (8, 16 or 32); stable while not idle
//   PAR_EN          parity bit present; latched when a start is detected
//   PAR_TYP         0 = even, 1 = odd; latched when a start is detected
//   BIT_CNT         bit index from the edge/bit counter
//   EDG_CNT         edge index within the current bit, from the counter
//   EDG_BIT_CNT_EN  counter enable, high in every state except IDLE
//   P_DATA          last byte received without error
//   DATA_VALID      one-cycle strobe when P_DATA is updated
//   PAR_ERR         one-cycle strobe, parity mismatch on the completed frame
//   STP_ERR         one-cycle strobe, stop bit sampled low
//   fsm_state       current FSM state, for observation
//
// Handshake: there is no backpressure. DATA_VALID and the error strobes are
// single-cycle qualifiers. The downstream synchronizer must capture P_DATA in
// the cycle DATA_VALID is high.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [3:0]            BIT_CNT,
    input  logic [4:0]            EDG_CNT,
    output logic                  EDG_BIT_CNT_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);
    localparam logic [3:0] MAX_BIT   = 4'(DATA_WIDTH + 2);

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  s_mid;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag;
    logic                  voted;
    logic                  bit_end;
    logic                  bit_overflow;
    logic                  stop_end;
    logic [5:0]            edg_ext;
    logic [5:0]            half;

    // Compare at 6 bits so PRESCALE = 32 (last edge 31) needs no special case.
    assign edg_ext = {1'b0, EDG_CNT};
    assign half    = PRESCALE >> 1;
    assign bit_end = (edg_ext == PRESCALE - 6'd1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s_lo;
    logic s_hi;
    assign voted = (s_lo & s_mid) | (s_lo & s_hi) | (s_mid & s_hi);
`else
    assign voted = s_mid;
`endif

    // A bit index past the last possible stop bit means the counter and the
    // FSM have lost alignment. Abandon the frame silently.
    assign bit_overflow = (state != IDLE) && (BIT_CNT > MAX_BIT);
    assign stop_end     = (state == STOP) && bit_end && !bit_overflow;

    assign EDG_BIT_CNT_EN = (state != IDLE);
    assign fsm_state      = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (bit_end && BIT_CNT == 4'd0) next_state = voted ? IDLE : DATA;
            DATA:    if (bit_end && BIT_CNT == LAST_DATA) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bit_overflow) next_state = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            s_mid      <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            s_lo       <= 1'b0;
            s_hi       <= 1'b0;
`endif
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag   <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            state      <= next_state;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            // Freeze the line format for the whole frame at start detect.
            if (state == IDLE && !RX_IN) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_flag  <= 1'b0;
            end

            if (state != IDLE) begin
                if (edg_ext == half) s_mid <= RX_IN;
`ifdef UART_RX_MAJORITY_VOTE_EN
                if (edg_ext == half - 6'd1) s_lo <= RX_IN;
                if (edg_ext == half + 6'd1) s_hi <= RX_IN;
`endif
            end

            // Right shift with the new bit at the MSB, so the first data bit
            // ends up in bit 0.
            if (state == DATA && bit_end)
                shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};

            if (state == PARITY && bit_end)
                par_flag <= voted ^ (^shift_reg) ^ par_typ_q;

            if (stop_end) begin
                STP_ERR <= ~voted;
                PAR_ERR <= par_flag;
                if (voted && !par_flag) begin
                    DATA_VALID <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl. The bench contains a behavioural model of the
// edge/bit counter that drives BIT_CNT/EDG_CNT from EDG_BIT_CNT_EN. It also
// contains a serial line driver and one task per scenario. Each task has its
// own inline checks.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [3:0] BIT_CNT;
    logic [4:0] EDG_CNT;
    logic       EDG_BIT_CNT_EN;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic [2:0] fsm_state;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .BIT_CNT(BIT_CNT), .EDG_CNT(EDG_CNT),
        .EDG_BIT_CNT_EN(EDG_BIT_CNT_EN), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- edge/bit counter model ----------------
    logic [4:0] edg_q;
    logic [3:0] bit_q;
    logic       bit_force_on = 1'b0;
    logic [3:0] bit_force_val = 4'd0;

    always @(posedge CLK) begin
        if (!EDG_BIT_CNT_EN) begin
            edg_q <= 5'd0;
            bit_q <= 4'd0;
        end else if (edg_q == 5'(PRESCALE - 6'd1)) begin
            edg_q <= 5'd0;
            bit_q <= bit_q + 4'd1;
        end else begin
            edg_q <= edg_q + 5'd1;
        end
    end

    assign EDG_CNT = edg_q;
    assign BIT_CNT = bit_force_on ? bit_force_val : bit_q;

    // ---------------- output monitor ----------------
    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         dv_cyc = 0;
    int         pe_cyc = 0;
    int         se_cyc = 0;
    logic [7:0] dv_last = 8'h00;
    logic [7:0] dv_q[$];
    int         dv_cyc_q[$];

    always @(negedge CLK) begin
        if (RST) begin
            if (DATA_VALID) begin
                dv_cnt++;
                dv_cyc = cyc;
                dv_last = P_DATA;
                dv_q.push_back(P_DATA);
                dv_cyc_q.push_back(cyc);
            end
            if (PAR_ERR) begin
                pe_cnt++;
                pe_cyc = cyc;
            end
            if (STP_ERR) begin
                se_cnt++;
                se_cyc = cyc;
            end
        end
    end

    // ---------------- line driver ----------------
    // Enter on a negedge. Interval i of the frame starts at cycle start_cyc + i.
    // flip_i inverts the line for that single interval only (-1 = none).
    task automatic send_frame(input logic [7:0] data, input bit par_en,
                              input bit par_bit, input bit stop_bit,
                              input int flip_i, output int start_cyc);
        logic [11:0] fb;
        int nbits;
        int p;
        logic b;
        p = int'(PRESCALE);
        fb = '1;
        fb[0] = 1'b0;
        for (int j = 0; j < 8; j++) fb[1+j] = data[j];
        if (par_en) begin
            fb[9] = par_bit;
            fb[10] = stop_bit;
            nbits = 11;
        end else begin
            fb[9] = stop_bit;
            nbits = 10;
        end
        start_cyc = cyc;
        for (int i = 0; i < nbits * p; i++) begin
            b = fb[i / p];
            RX_IN = (i == flip_i) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b expected 0", EDG_BIT_CNT_EN); end
        vectors++;
        if (P_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
        vectors++;
        if ({DATA_VALID, PAR_ERR, STP_ERR} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b expected 000", {DATA_VALID, PAR_ERR, STP_ERR}); end
        vectors++;
        if (fsm_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b0) begin miscompares++; $display("FAIL idle_line_en: got %b expected 0", EDG_BIT_CNT_EN); end
    endtask

    task automatic test_basic;
        int d, b_dv, b_pe, b_se;
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1) begin miscompares++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - b_dv); end
        vectors++;
        if (dv_last !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h expected a5", dv_last); end
        vectors++;
        if (dv_cyc - d !== 81) begin miscompares++; $display("FAIL basic_latency: got %0d expected 81", dv_cyc - d); end
        vectors++;
        if ((pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin miscompares++; $display("FAIL basic_no_err: got %0d expected 0", (pe_cnt - b_pe) + (se_cnt - b_se)); end
    endtask

    task automatic test_parity;
        int d, b_dv, b_pe, b_se;
        PRESCALE = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        // 0x3C has four ones: even parity bit 0 is correct.
        b_dv = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1) begin miscompares++; $display("FAIL even_ok_dv: got %0d expected 1", dv_cnt - b_dv); end
        vectors++;
        if (dv_last !== 8'h3C) begin miscompares++; $display("FAIL even_ok_data: got %h expected 3c", dv_last); end
        vectors++;
        if (dv_cyc - d !== 177) begin miscompares++; $display("FAIL even_ok_latency: got %0d expected 177", dv_cyc - d); end
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (pe_cnt - b_pe !== 1) begin miscompares++; $display("FAIL even_bad_pe: got %0d expected 1", pe_cnt - b_pe); end
        vectors++;
        if (pe_cyc - d !== 177) begin miscompares++; $display("FAIL even_bad_latency: got %0d expected 177", pe_cyc - d); end
        vectors++;
        if ((dv_cnt - b_dv) + (se_cnt - b_se) !== 0) begin miscompares++; $display("FAIL even_bad_other: got %0d expected 0", (dv_cnt - b_dv) + (se_cnt - b_se)); end
        vectors++;
        if (P_DATA !== 8'h3C) begin miscompares++; $display("FAIL even_bad_hold: got %h expected 3c", P_DATA); end
        // Odd parity: 0x3C needs parity bit 1.
        PAR_TYP = 1'b1;
        b_dv = dv_cnt; b_pe = pe_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1 || pe_cnt - b_pe !== 0) begin miscompares++; $display("FAIL odd_ok: got dv %0d pe %0d expected dv 1 pe 0", dv_cnt - b_dv, pe_cnt - b_pe); end
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
    endtask

    task automatic test_framing;
        int d, b_dv, b_se;
        PRESCALE = 6'd32;
        PAR_EN = 1'b0;
        b_dv = dv_cnt; b_se = se_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, d);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        vectors++;
        if (se_cnt - b_se !== 1) begin miscompares++; $display("FAIL stop_err_count: got %0d expected 1", se_cnt - b_se); end
        vectors++;
        if (se_cyc - d !== 321) begin miscompares++; $display("FAIL stop_err_latency: got %0d expected 321", se_cyc - d); end
        vectors++;
        if (dv_cnt - b_dv !== 0) begin miscompares++; $display("FAIL stop_err_no_dv: got %0d expected 0", dv_cnt - b_dv); end
        vectors++;
        if (P_DATA !== 8'h3C) begin miscompares++; $display("FAIL stop_err_hold: got %h expected 3c", P_DATA); end
        b_dv = dv_cnt;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1 || dv_last !== 8'h7E) begin miscompares++; $display("FAIL after_stop_err: got dv %0d data %h expected dv 1 data 7e", dv_cnt - b_dv, dv_last); end
    endtask

    task automatic test_glitch;
        int b_all;
        PRESCALE = 6'd8;
        b_all = dv_cnt + pe_cnt + se_cnt;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b1) begin miscompares++; $display("FAIL glitch_en_last_start: got %b expected 1", EDG_BIT_CNT_EN); end
        @(negedge CLK);
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b0 || fsm_state !== 3'd0) begin miscompares++; $display("FAIL glitch_idle: got en %b state %0d expected en 0 state 0", EDG_BIT_CNT_EN, fsm_state); end
        repeat (100) @(negedge CLK);
        vectors++;
        if (dv_cnt + pe_cnt + se_cnt - b_all !== 0) begin miscompares++; $display("FAIL glitch_strobes: got %0d expected 0", dv_cnt + pe_cnt + se_cnt - b_all); end
    endtask

    task automatic test_noise;
        int d, b_dv;
        logic [7:0] exp_mid;
        PRESCALE = 6'd16;
        PAR_EN = 1'b0;
        // Data bit 3 is frame bit 4; EDG_CNT = e falls in interval 1 + 4*16 + e.
        b_dv = dv_cnt;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1 + 64 + 9, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1 || dv_last !== 8'hF0) begin miscompares++; $display("FAIL noise_h_plus1: got dv %0d data %h expected dv 1 data f0", dv_cnt - b_dv, dv_last); end
`ifdef UART_RX_MAJORITY_VOTE_EN
        exp_mid = 8'hF0;
`else
        exp_mid = 8'hF8;
`endif
        b_dv = dv_cnt;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1 + 64 + 8, d);
        repeat (4) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 1 || dv_last !== exp_mid) begin miscompares++; $display("FAIL noise_h: got dv %0d data %h expected dv 1 data %h", dv_cnt - b_dv, dv_last, exp_mid); end
    endtask

    task automatic test_mid_reset;
        int b_all;
        PRESCALE = 6'd8;
        b_all = dv_cnt + pe_cnt + se_cnt;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        vectors++;
        if (fsm_state !== 3'd2 || EDG_BIT_CNT_EN !== 1'b1) begin miscompares++; $display("FAIL mid_reset_in_data: got state %0d en %b expected state 2 en 1", fsm_state, EDG_BIT_CNT_EN); end
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (fsm_state !== 3'd0 || EDG_BIT_CNT_EN !== 1'b0) begin miscompares++; $display("FAIL mid_reset_idle: got state %0d en %b expected state 0 en 0", fsm_state, EDG_BIT_CNT_EN); end
        vectors++;
        if (P_DATA !== 8'h00 || {DATA_VALID, PAR_ERR, STP_ERR} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_outputs: got data %h strobes %b expected 00 000", P_DATA, {DATA_VALID, PAR_ERR, STP_ERR}); end
        RST = 1'b1;
        repeat (100) @(negedge CLK);
        vectors++;
        if (dv_cnt + pe_cnt + se_cnt - b_all !== 0 || EDG_BIT_CNT_EN !== 1'b0) begin miscompares++; $display("FAIL mid_reset_quiet: got strobes %0d en %b expected 0 0", dv_cnt + pe_cnt + se_cnt - b_all, EDG_BIT_CNT_EN); end
    endtask

    task automatic test_bit_overflow;
        int b_all;
        PRESCALE = 6'd8;
        b_all = dv_cnt + pe_cnt + se_cnt;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        // 10 is still a legal index and must not abort the frame.
        bit_force_val = 4'd10;
        bit_force_on = 1'b1;
        @(negedge CLK);
        bit_force_on = 1'b0;
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b1) begin miscompares++; $display("FAIL bitcnt_10_kept: got en %b expected 1", EDG_BIT_CNT_EN); end
        bit_force_val = 4'd11;
        bit_force_on = 1'b1;
        @(negedge CLK);
        bit_force_on = 1'b0;
        vectors++;
        if (EDG_BIT_CNT_EN !== 1'b0 || fsm_state !== 3'd0) begin miscompares++; $display("FAIL bitcnt_11_abort: got en %b state %0d expected en 0 state 0", EDG_BIT_CNT_EN, fsm_state); end
        repeat (100) @(negedge CLK);
        vectors++;
        if (dv_cnt + pe_cnt + se_cnt - b_all !== 0) begin miscompares++; $display("FAIL bitcnt_strobes: got %0d expected 0", dv_cnt + pe_cnt + se_cnt - b_all); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int d1, d2, b_dv, b_err, c1, c2;
        logic [7:0] got;
        PRESCALE = 6'd8;
        PAR_EN = 1'b0;
        dv_q.delete();
        dv_cyc_q.delete();
        b_dv = dv_cnt;
        b_err = pe_cnt + se_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        fork
            begin
                send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, d1);
                send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1, d2);
            end
            begin
                repeat (20) @(negedge CLK);
                PAR_EN = 1'b1;
                repeat (40) @(negedge CLK);
                PAR_EN = 1'b0;
                repeat (40) @(negedge CLK);
                PAR_EN = 1'b1;
                repeat (40) @(negedge CLK);
                PAR_EN = 1'b0;
            end
        join
        repeat (8) @(negedge CLK);
        vectors++;
        if (dv_cnt - b_dv !== 2) begin miscompares++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_cnt - b_dv); end
        vectors++;
        if (pe_cnt + se_cnt - b_err !== 0) begin miscompares++; $display("FAIL b2b_no_err: got %0d expected 0", pe_cnt + se_cnt - b_err); end
        while (exp_q.size() > 0) begin
            got = (dv_q.size() > 0) ? dv_q.pop_front() : 8'hxx;
            vectors++;
            if (got !== exp_q[0]) begin miscompares++; $display("FAIL b2b_data: got %h expected %h", got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        c1 = (dv_cyc_q.size() > 0) ? dv_cyc_q[0] : 0;
        c2 = (dv_cyc_q.size() > 1) ? dv_cyc_q[1] : 0;
        vectors++;
        if (c1 - d1 !== 81 || c2 - c1 !== 81) begin miscompares++; $display("FAIL b2b_timing: got %0d/%0d expected 81/81", c1 - d1, c2 - c1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_noise();
        test_mid_reset();
        test_bit_overflow();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
